// File: rtl/gtfmac_vnc_lat_pkg.sv
// Shared types and constants for the transmit-side latency probe generator.
package gtfmac_vnc_lat_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    GAP  = 3'd3,
    DONE = 3'd4
  } lat_gen_state_t;

  // Shortest low time on pattern_sent that the rx_clk edge detector reliably sees.
  localparam int unsigned MIN_LOW_CYC_DEF = 8;

  // Effective inter-probe idle time: the programmed gap, floored at the minimum low time.
  function automatic logic [15:0] gap_len(input logic [15:0] gap, input logic [15:0] min_low);
    return (gap > min_low) ? gap : min_low;
  endfunction

endpackage

// File: rtl/syncer_level.sv
// Two-flop level synchronizer for slow asynchronous control levels.
module syncer_level #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] datain,
  output logic [WIDTH-1:0] dataout
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two-stage capture; output is the second stage.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= datain;
      sync_q <= meta_q;
    end
  end

  assign dataout = sync_q;

endmodule

// File: rtl/gtfmac_vnc_lat_gen.sv
// Transmit-side latency probe generator (tx_clk domain).
// Paces probe insertion requests to the TX datapath, drives pattern_sent to the
// latency monitor, waits for the far-end pattern_rcvd, enforces an idle gap and
// stops after lat_pkt_cnt probes.
// Optional feature macro: GTFMAC_VNC_LAT_TIMEOUT_EN (WAIT-state timeout and
// timeout_cnt). Without it WAIT waits indefinitely and timeout_cnt is tied to 0.
//
// state | meaning
// IDLE  | no run; waiting for a go rising edge
// REQ   | pat_req high, waiting for the datapath ack
// WAIT  | probe in flight, pattern_sent high, waiting for pattern_rcvd
// GAP   | pattern_sent low for max(gap_cycles, MIN_LOW_CYC) cycles
// DONE  | run complete, done high until go falls
module gtfmac_vnc_lat_gen
  import gtfmac_vnc_lat_pkg::*;
#(
  parameter int unsigned MIN_LOW_CYC = MIN_LOW_CYC_DEF,
  parameter int unsigned TIMEOUT_CYC = 65535,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                 tx_clk_i,
  input  logic                 tx_rst_i,
  input  logic                 go_i,
  input  logic                 stop_i,
  input  logic [CNT_WIDTH-1:0] lat_pkt_cnt_i,
  input  logic [15:0]          gap_cycles_i,
  output logic                 pat_req_o,
  input  logic                 pat_ack_i,
  output logic                 pattern_sent_o,
  input  logic                 pattern_rcvd_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CNT_WIDTH-1:0] sent_cnt_o,
  output logic [15:0]          timeout_cnt_o
);

  // Shared gap/timeout down-counter; one extra bit only if the timeout needs it.
  localparam int TMR_W = (TIMEOUT_CYC > 65535) ? 17 : 16;
  localparam logic [15:0] MIN_LOW16 = 16'(MIN_LOW_CYC);

  lat_gen_state_t state_q, state_d;
  logic                 pat_req_q, pat_req_d;
  logic                 sent_q, sent_d;
  logic                 done_q, done_d;
  logic [CNT_WIDTH-1:0] sent_cnt_q, sent_cnt_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic                 go_prev_q, rcvd_prev_q;

  logic rst_n;
  logic go_s, stop_s, rcvd_s;
  logic go_rise, rcvd_rise;
  logic [TMR_W-1:0] gap_load;

  assign rst_n = ~tx_rst_i;

  syncer_level #(.WIDTH(1)) u_sync_go (
    .clk     (tx_clk_i),
    .resetn  (rst_n),
    .datain  (go_i),
    .dataout (go_s)
  );

  syncer_level #(.WIDTH(1)) u_sync_stop (
    .clk     (tx_clk_i),
    .resetn  (rst_n),
    .datain  (stop_i),
    .dataout (stop_s)
  );

  syncer_level #(.WIDTH(1)) u_sync_rcvd (
    .clk     (tx_clk_i),
    .resetn  (rst_n),
    .datain  (pattern_rcvd_i),
    .dataout (rcvd_s)
  );

  assign go_rise   = go_s & ~go_prev_q;
  assign rcvd_rise = rcvd_s & ~rcvd_prev_q;

  // Counter terminates at zero, so load one less than the desired GAP length.
  assign gap_load = TMR_W'(gap_len(gap_cycles_i, MIN_LOW16) - 16'd1);

`ifdef GTFMAC_VNC_LAT_TIMEOUT_EN
  localparam logic [TMR_W-1:0] TO_LOAD = TMR_W'(TIMEOUT_CYC - 1);
  logic [15:0] to_cnt_q, to_cnt_d;
`endif

  // Next-state and registered-output logic; stop overrides everything.
  always_comb begin
    state_d    = state_q;
    pat_req_d  = pat_req_q;
    sent_d     = sent_q;
    done_d     = done_q;
    sent_cnt_d = sent_cnt_q;
    tmr_d      = tmr_q;
`ifdef GTFMAC_VNC_LAT_TIMEOUT_EN
    to_cnt_d   = to_cnt_q;
`endif
    if (stop_s) begin
      state_d   = IDLE;
      pat_req_d = 1'b0;
      sent_d    = 1'b0;
      done_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (go_rise && (lat_pkt_cnt_i != '0)) begin
            sent_cnt_d = '0;
`ifdef GTFMAC_VNC_LAT_TIMEOUT_EN
            to_cnt_d   = '0;
`endif
            pat_req_d  = 1'b1;
            state_d    = REQ;
          end
        end
        REQ: begin
          if (pat_ack_i) begin
            sent_cnt_d = sent_cnt_q + 1'b1;
            pat_req_d  = 1'b0;
            sent_d     = 1'b1;
            state_d    = WAIT;
`ifdef GTFMAC_VNC_LAT_TIMEOUT_EN
            tmr_d      = TO_LOAD;
`endif
          end
        end
        WAIT: begin
          if (rcvd_rise) begin
            sent_d  = 1'b0;
            tmr_d   = gap_load;
            state_d = GAP;
          end
`ifdef GTFMAC_VNC_LAT_TIMEOUT_EN
          else if (tmr_q == '0) begin
            sent_d  = 1'b0;
            tmr_d   = gap_load;
            state_d = GAP;
            if (to_cnt_q != 16'hFFFF) to_cnt_d = to_cnt_q + 16'd1;
          end else begin
            tmr_d = tmr_q - 1'b1;
          end
`endif
        end
        GAP: begin
          if (tmr_q == '0) begin
            // >= rather than == so a mid-run lat_pkt_cnt change cannot run forever.
            if (sent_cnt_q >= lat_pkt_cnt_i) begin
              done_d  = 1'b1;
              state_d = DONE;
            end else begin
              pat_req_d = 1'b1;
              state_d   = REQ;
            end
          end else begin
            tmr_d = tmr_q - 1'b1;
          end
        end
        DONE: begin
          if (!go_s) begin
            done_d  = 1'b0;
            state_d = IDLE;
          end
        end
        default: begin
          state_d   = IDLE;
          pat_req_d = 1'b0;
          sent_d    = 1'b0;
          done_d    = 1'b0;
        end
      endcase
    end
  end

  // State, output and counter registers; async reset returns everything to idle.
  always_ff @(posedge tx_clk_i or posedge tx_rst_i) begin
    if (tx_rst_i) begin
      state_q     <= IDLE;
      pat_req_q   <= 1'b0;
      sent_q      <= 1'b0;
      done_q      <= 1'b0;
      sent_cnt_q  <= '0;
      tmr_q       <= '0;
      go_prev_q   <= 1'b0;
      rcvd_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pat_req_q   <= pat_req_d;
      sent_q      <= sent_d;
      done_q      <= done_d;
      sent_cnt_q  <= sent_cnt_d;
      tmr_q       <= tmr_d;
      go_prev_q   <= go_s;
      rcvd_prev_q <= rcvd_s;
    end
  end

`ifdef GTFMAC_VNC_LAT_TIMEOUT_EN
  // Abandoned-probe counter.
  always_ff @(posedge tx_clk_i or posedge tx_rst_i) begin
    if (tx_rst_i) to_cnt_q <= '0;
    else          to_cnt_q <= to_cnt_d;
  end
  assign timeout_cnt_o = to_cnt_q;
`else
  assign timeout_cnt_o = '0;
`endif

  assign pat_req_o      = pat_req_q;
  assign pattern_sent_o = sent_q;
  assign done_o         = done_q;
  assign sent_cnt_o     = sent_cnt_q;
  assign busy_o         = (state_q == REQ) || (state_q == WAIT) || (state_q == GAP);

endmodule

// File: tb/tb_gtfmac_vnc_lat_gen.sv
// Self-checking bench for gtfmac_vnc_lat_gen: a responder models the TX datapath
// (pat_ack) and the far end (pattern_rcvd); a queue holds the expected sent_cnt
// for each acknowledged probe, checked when pattern_sent rises.
module tb_gtfmac_vnc_lat_gen;

  logic        tx_clk = 1'b0;
  logic        tx_rst = 1'b1;
  logic        go = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] lat_pkt_cnt = '0;
  logic [15:0] gap_cycles = '0;
  logic        pat_req;
  logic        pat_ack = 1'b0;
  logic        pattern_sent;
  logic        pattern_rcvd = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] sent_cnt;
  logic [15:0] timeout_cnt;

  gtfmac_vnc_lat_gen #(
    .MIN_LOW_CYC (8),
    .TIMEOUT_CYC (100),
    .CNT_WIDTH   (32)
  ) dut (
    .tx_clk_i       (tx_clk),
    .tx_rst_i       (tx_rst),
    .go_i           (go),
    .stop_i         (stop),
    .lat_pkt_cnt_i  (lat_pkt_cnt),
    .gap_cycles_i   (gap_cycles),
    .pat_req_o      (pat_req),
    .pat_ack_i      (pat_ack),
    .pattern_sent_o (pattern_sent),
    .pattern_rcvd_i (pattern_rcvd),
    .busy_o         (busy),
    .done_o         (done),
    .sent_cnt_o     (sent_cnt),
    .timeout_cnt_o  (timeout_cnt)
  );

  always #5 tx_clk = ~tx_clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  bit resp_en = 0;
  int ack_dly, rcvd_dly, exp_low;
  int req_age, rcvd_age, rise_cyc, fall_cyc, rises;
  logic ps_prev = 1'b0;
  logic pr_prev = 1'b0;
  int unsigned exp_next;
  int unsigned exp_q[$];

  typedef struct {
    int unsigned n;
    int unsigned gap;
    int          ack_dly;
    int          rcvd_dly;
    int          exp_low;
    int unsigned exp_sent;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic resp_reset();
    exp_q.delete();
    exp_next     = 1;
    req_age      = 0;
    rcvd_age     = 0;
    rise_cyc     = -1;
    fall_cyc     = -1;
    rises        = 0;
    pattern_rcvd = 1'b0;
  endtask

  // One tx_clk cycle; sample on the falling edge and play datapath/far end.
  task automatic step();
    @(negedge tx_clk);
    cyc++;
    pat_ack = 1'b0;
    if (resp_en) begin
      if (pat_req) begin
        if (!pr_prev && fall_cyc >= 0) chk("gap_low", cyc - fall_cyc, exp_low);
        req_age++;
        if (req_age == ack_dly) begin
          pat_ack = 1'b1;
          exp_q.push_back(exp_next);
          exp_next++;
        end
      end else begin
        req_age = 0;
      end
      if (pattern_sent && !ps_prev) begin
        rises++;
        rise_cyc = cyc;
        rcvd_age = 0;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_underflow: pattern_sent rose with no acknowledged probe (cycle %0d)", cyc);
        end else begin
          chk("sent_cnt_at_rise", sent_cnt, exp_q.pop_front());
        end
      end else if (pattern_sent && rcvd_dly >= 0) begin
        rcvd_age++;
        if (rcvd_age == rcvd_dly) pattern_rcvd = 1'b1;
      end
      if (!pattern_sent && ps_prev) begin
        if (rcvd_dly >= 0) chk("pulse_width", cyc - rise_cyc, rcvd_dly + 3);
        fall_cyc     = cyc;
        pattern_rcvd = 1'b0;
      end
    end
    ps_prev = pattern_sent;
    pr_prev = pat_req;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    vecs[0] = '{n: 3, gap: 20, ack_dly: 5, rcvd_dly: 40, exp_low: 20, exp_sent: 3};
    vecs[1] = '{n: 2, gap: 0,  ack_dly: 1, rcvd_dly: 10, exp_low: 8,  exp_sent: 2};
    vecs[2] = '{n: 1, gap: 5,  ack_dly: 3, rcvd_dly: 6,  exp_low: 8,  exp_sent: 1};
    vecs[3] = '{n: 2, gap: 12, ack_dly: 2, rcvd_dly: 15, exp_low: 12, exp_sent: 2};

    // Reset values
    repeat (3) @(negedge tx_clk);
    chk("rst_pat_req", pat_req, 0);
    chk("rst_pattern_sent", pattern_sent, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sent_cnt", sent_cnt, 0);
    chk("rst_timeout_cnt", timeout_cnt, 0);
    tx_rst = 1'b0;
    repeat (3) step();

    // go rising with lat_pkt_cnt == 0 is ignored
    lat_pkt_cnt = 0;
    go = 1'b1;
    repeat (10) step();
    chk("zero_cnt_busy", busy, 0);
    chk("zero_cnt_done", done, 0);
    chk("zero_cnt_req", pat_req, 0);
    go = 1'b0;
    repeat (4) step();

    // Table-driven complete runs
    for (int i = 0; i < 4; i++) begin
      lat_pkt_cnt = vecs[i].n;
      gap_cycles  = 16'(vecs[i].gap);
      ack_dly     = vecs[i].ack_dly;
      rcvd_dly    = vecs[i].rcvd_dly;
      exp_low     = vecs[i].exp_low;
      resp_reset();
      resp_en = 1;
      go = 1'b1;
      k = 0;
      while (!done && k < 5000) begin step(); k++; end
      chk("run_done", done, 1);
      chk("run_sent_cnt", sent_cnt, vecs[i].exp_sent);
      chk("run_pulses", rises, vecs[i].exp_sent);
      chk("run_busy", busy, 0);
      chk("run_sb_empty", exp_q.size(), 0);
      go = 1'b0;
      repeat (4) step();
      chk("run_done_clear", done, 0);
    end

    // stop during WAIT of probe 2 of 5, then restart clears sent_cnt
    lat_pkt_cnt = 5; gap_cycles = 8; ack_dly = 2; rcvd_dly = 10; exp_low = 8;
    resp_reset();
    resp_en = 1;
    go = 1'b1;
    k = 0;
    while (!(sent_cnt == 2 && pattern_sent) && k < 2000) begin step(); k++; end
    chk("stop_reach_probe2", sent_cnt, 2);
    resp_en = 0;
    pattern_rcvd = 1'b0;
    stop = 1'b1;
    repeat (5) step();
    chk("stop_pattern_sent", pattern_sent, 0);
    chk("stop_pat_req", pat_req, 0);
    chk("stop_busy", busy, 0);
    chk("stop_done", done, 0);
    chk("stop_sent_cnt", sent_cnt, 2);
    stop = 1'b0;
    repeat (4) step();
    chk("stop_cnt_held", sent_cnt, 2);
    go = 1'b0;
    repeat (4) step();
    resp_reset();
    ack_dly = 50;
    resp_en = 1;
    go = 1'b1;
    k = 0;
    while (!pat_req && k < 50) begin step(); k++; end
    chk("restart_req", pat_req, 1);
    chk("restart_cnt_clear", sent_cnt, 0);
    resp_en = 0;
    stop = 1'b1;
    repeat (5) step();
    chk("abort2_pat_req", pat_req, 0);
    stop = 1'b0;
    go = 1'b0;
    repeat (4) step();

    // Stray rcvd in REQ and stray ack in GAP are ignored
    lat_pkt_cnt = 1; gap_cycles = 10; ack_dly = 30; rcvd_dly = 10; exp_low = 10;
    resp_reset();
    resp_en = 1;
    go = 1'b1;
    k = 0;
    while (!pat_req && k < 50) begin step(); k++; end
    pattern_rcvd = 1'b1;
    repeat (4) step();
    pattern_rcvd = 1'b0;
    repeat (3) step();
    chk("stray_rcvd_req", pat_req, 1);
    chk("stray_rcvd_sent", pattern_sent, 0);
    chk("stray_rcvd_cnt", sent_cnt, 0);
    k = 0;
    while (fall_cyc < 0 && k < 200) begin step(); k++; end
    pat_ack = 1'b1;
    step();
    chk("stray_ack_cnt", sent_cnt, 1);
    chk("stray_ack_req", pat_req, 0);
    chk("stray_ack_sent", pattern_sent, 0);
    chk("stray_ack_busy", busy, 1);
    k = 0;
    while (!done && k < 200) begin step(); k++; end
    chk("stray_done", done, 1);
    chk("stray_final_cnt", sent_cnt, 1);
    go = 1'b0;
    repeat (4) step();

    // pattern_rcvd never arrives
    lat_pkt_cnt = 2; gap_cycles = 0; ack_dly = 1; rcvd_dly = -1; exp_low = 8;
    resp_reset();
    resp_en = 1;
    go = 1'b1;
`ifdef GTFMAC_VNC_LAT_TIMEOUT_EN
    k = 0;
    while (!done && k < 1000) begin step(); k++; end
    chk("to_done", done, 1);
    chk("to_timeout_cnt", timeout_cnt, 2);
    chk("to_sent_cnt", sent_cnt, 2);
    chk("to_done_time_window", (k >= 215 && k <= 230), 1);
    go = 1'b0;
    repeat (4) step();
`else
    repeat (400) step();
    chk("nto_busy", busy, 1);
    chk("nto_pattern_sent", pattern_sent, 1);
    chk("nto_sent_cnt", sent_cnt, 1);
    chk("nto_timeout_cnt", timeout_cnt, 0);
    resp_en = 0;
    stop = 1'b1;
    repeat (5) step();
    stop = 1'b0;
    go = 1'b0;
    repeat (4) step();
`endif

    // Async reset in the middle of the second REQ
    lat_pkt_cnt = 4; gap_cycles = 8; ack_dly = 3; rcvd_dly = 5; exp_low = 8;
    resp_reset();
    resp_en = 1;
    go = 1'b1;
    k = 0;
    while (!(sent_cnt == 1 && pat_req) && k < 500) begin step(); k++; end
    chk("rstmid_reach_req2", pat_req, 1);
    tx_rst = 1'b1;
    #1;
    chk("rstmid_pat_req", pat_req, 0);
    chk("rstmid_pattern_sent", pattern_sent, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_done", done, 0);
    chk("rstmid_sent_cnt", sent_cnt, 0);
    resp_en = 0;
    go = 1'b0;
    pattern_rcvd = 1'b0;
    repeat (3) step();
    tx_rst = 1'b0;
    repeat (5) step();
    chk("rstmid_stay_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
